// File: rtl/host_pkt_pkg.sv
// rtl/host_pkt_pkg.sv - packet layout constants, assembler states and byte swizzle helper for host_pkt_decoder
package host_pkt_pkg;

    localparam int WORDS_PER_PKT = 8;
    localparam int PKT_W         = 256;
    localparam int IS_DRAM_BIT   = 156;
    localparam int IS_READ_BIT   = 155;
    localparam int ADDR_LSB      = 128;
    localparam int RSVD_LSB      = 157;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } asm_state_t;

    // Overlay of the reassembled 256-bit host packet.
    typedef struct packed {
        logic [PKT_W-1:RSVD_LSB]      rsvd;
        logic                         is_dram;
        logic                         is_read;
        logic [IS_READ_BIT-1:ADDR_LSB] addr;
        logic [ADDR_LSB-1:0]          wdata;
    } host_pkt_t;

    // The host sends each word with its bytes reversed; undo that.
    function automatic logic [31:0] byte_rev32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/host_pkt_decoder.sv
// rtl/host_pkt_decoder.sv - reassembles 8 pipe-in words into a host packet and presents the decoded DRAM command
//
// Ports:
//   clk, rst                 okClk and synchronous active-high reset
//   ep_write, ep_dataout     pipe-in word strobe and byte-swizzled word
//   ep_ready                 high while a whole packet can be collected
//   cmd_valid, cmd_ready     single-entry command handshake toward the DDR3 path
//   cmd_is_dram, cmd_is_read, cmd_addr, cmd_wdata   decoded command fields
//   pkt_count                handed-off command count (wraps)
//   err_reserved             sticky: a forwarded packet had reserved bits set
//   err_overflow             sticky: a word arrived while ep_ready was low
module host_pkt_decoder
    import host_pkt_pkg::*;
#(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ep_write,
    input  logic [31:0]       ep_dataout,
    output logic              ep_ready,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_is_dram,
    output logic              cmd_is_read,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_wdata,
    output logic [31:0]       pkt_count,
    output logic              err_reserved,
    output logic              err_overflow
);

    asm_state_t          state;
    logic [2:0]          idx;
    logic [PKT_W-1:0]    buf_q;
    logic [RSVD_LSB-1:0] out_q;
    logic                out_valid;

    logic [31:0] word_in;
    logic        accept;
    logic        last_word;
    logic        can_load;
    logic        do_load;
    host_pkt_t   load_pkt;

    always_comb begin
        word_in   = byte_rev32(ep_dataout);
        accept    = ep_write && (state == ST_COLLECT);
        last_word = accept && (idx == 3'(WORDS_PER_PKT - 1));
        // The output entry is free if empty or being consumed this cycle.
        can_load  = !out_valid || cmd_ready;
        do_load   = can_load && (last_word || (state == ST_HOLD));
        // In HOLD the whole packet is already buffered; otherwise the last
        // word bypasses the buffer so the packet lands with no extra cycle.
        if (state == ST_HOLD) begin
            load_pkt = host_pkt_t'(buf_q);
        end else begin
            load_pkt = host_pkt_t'({word_in, buf_q[PKT_W-33:0]});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_COLLECT;
            idx          <= '0;
            buf_q        <= '0;
            out_q        <= '0;
            out_valid    <= 1'b0;
            ep_ready     <= 1'b1;
            pkt_count    <= '0;
            err_reserved <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (accept) begin
                buf_q[{idx, 5'b0} +: 32] <= word_in;
                idx                      <= idx + 3'd1;
            end

            case (state)
                ST_COLLECT: begin
                    if (last_word && !can_load) begin
                        state    <= ST_HOLD;
                        ep_ready <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (ep_write) begin
                        err_overflow <= 1'b1;
                    end
                    if (can_load) begin
                        state    <= ST_COLLECT;
                        ep_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_COLLECT;
                    ep_ready <= 1'b1;
                end
            endcase

            if (do_load) begin
                out_q     <= load_pkt[RSVD_LSB-1:0];
                out_valid <= 1'b1;
                if (|load_pkt.rsvd) begin
                    err_reserved <= 1'b1;
                end
            end else if (out_valid && cmd_ready) begin
                out_valid <= 1'b0;
            end

            if (out_valid && cmd_ready) begin
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end

    assign cmd_valid   = out_valid;
    assign cmd_is_dram = out_q[IS_DRAM_BIT];
    assign cmd_is_read = out_q[IS_READ_BIT];
    assign cmd_addr    = out_q[ADDR_LSB +: ADDR_W];
    assign cmd_wdata   = out_q[DATA_W-1:0];

endmodule

// File: tb/tb_host_pkt_decoder.sv
// tb/tb_host_pkt_decoder.sv - self-checking bench for host_pkt_decoder
module tb_host_pkt_decoder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ep_write = 1'b0;
    logic [31:0]  ep_dataout = '0;
    logic         ep_ready;
    logic         cmd_valid;
    logic         cmd_ready = 1'b1;
    logic         cmd_is_dram;
    logic         cmd_is_read;
    logic [26:0]  cmd_addr;
    logic [127:0] cmd_wdata;
    logic [31:0]  pkt_count;
    logic         err_reserved;
    logic         err_overflow;

    always #5 clk = ~clk;

    host_pkt_decoder #(.ADDR_W(27), .DATA_W(128)) dut (
        .clk          (clk),
        .rst          (rst),
        .ep_write     (ep_write),
        .ep_dataout   (ep_dataout),
        .ep_ready     (ep_ready),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_is_dram  (cmd_is_dram),
        .cmd_is_read  (cmd_is_read),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .pkt_count    (pkt_count),
        .err_reserved (err_reserved),
        .err_overflow (err_overflow)
    );

    int total = 0;
    int bad   = 0;

    logic [255:0] exp_q[$];
    int           model_count = 0;
    logic         rst_seen = 1'b0;
    int           ep_low_seen = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Host-side view: a packet is a value, sent as 8 byte-reversed words.
    function automatic logic [31:0] host_swizzle(input logic [31:0] w);
        logic [31:0] r;
        r = {<<8{w}};
        return r;
    endfunction

    function automatic logic [255:0] mk_pkt(input logic dram, input logic rd,
                                            input logic [26:0] a, input logic [127:0] d,
                                            input logic [98:0] rsvd);
        logic [255:0] p;
        p = '0;
        p[127:0]   = d;
        p[154:128] = a;
        p[155]     = rd;
        p[156]     = dram;
        p[255:157] = rsvd;
        return p;
    endfunction

    always @(posedge clk) rst_seen <= rst;

    // Compare process: every command on the port must be the oldest
    // outstanding packet, and pkt_count must equal handoffs seen so far.
    always @(negedge clk) begin
        logic [255:0] e;
        if (rst) begin
            if (rst_seen) begin
                chk("rst_ep_ready", ep_ready, 1);
                chk("rst_cmd_valid", cmd_valid, 0);
                chk("rst_pkt_count", pkt_count, 0);
                chk("rst_errors", {err_reserved, err_overflow}, 0);
                chk("rst_fields", {cmd_is_dram, cmd_is_read, cmd_addr, cmd_wdata}, 0);
            end
            exp_q.delete();
            model_count = 0;
        end else begin
            chk("pkt_count", pkt_count, model_count);
            if (cmd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmd", cmd_valid, 0);
                end else begin
                    e = exp_q[0];
                    chk("cmd_fields", {cmd_is_dram, cmd_is_read, cmd_addr, cmd_wdata},
                        {e[156], e[155], e[154:128], e[127:0]});
                    if (cmd_ready) begin
                        void'(exp_q.pop_front());
                        model_count++;
                    end
                end
            end
        end
    end

    task automatic put_word(input logic [31:0] w);
        if (!ep_ready) ep_low_seen++;
        ep_write   = 1'b1;
        ep_dataout = w;
        @(posedge clk);
        #1;
        ep_write   = 1'b0;
        ep_dataout = '0;
    endtask

    task automatic send_pkt(input logic [255:0] p);
        for (int w = 0; w < 8; w++) begin
            put_word(host_swizzle(p[32*w +: 32]));
        end
        exp_q.push_back(p);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain;
        int n = 0;
        while (cmd_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", cmd_valid, 0);
    endtask

    initial begin
        logic [31:0]  t1_words [8];
        logic [255:0] p, pa, pb;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Literal write packet: addr 0, data {4{1}}, is_dram set via word 4.
        t1_words = '{32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000,
                     32'h0000_0010, 32'h0, 32'h0, 32'h0};
        cmd_ready = 1'b1;
        for (int i = 0; i < 8; i++) put_word(t1_words[i]);
        exp_q.push_back(mk_pkt(1'b1, 1'b0, 27'd0, {4{32'h0000_0001}}, '0));
        chk("t1_valid", cmd_valid, 1);
        chk("t1_is_dram", cmd_is_dram, 1);
        chk("t1_is_read", cmd_is_read, 0);
        chk("t1_addr", cmd_addr, 0);
        chk("t1_wdata", cmd_wdata, 128'h00000001_00000001_00000001_00000001);
        idle(1);
        chk("t1_count", pkt_count, 1);

        // Burst of 32 write packets back-to-back with cmd_ready high.
        ep_low_seen = 0;
        for (int i = 0; i < 32; i++) begin
            send_pkt(mk_pkt(1'b1, 1'b0, 27'(i), {4{32'(i + 1)}}, '0));
        end
        drain();
        chk("burst_ep_ready", ep_low_seen, 0);
        chk("burst_count", pkt_count, 33);
        chk("burst_errors", {err_reserved, err_overflow}, 0);

        // Read packet: valid appears right after the 8th word's edge.
        p = mk_pkt(1'b1, 1'b1, 27'd31, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, '0);
        for (int w = 0; w < 7; w++) put_word(host_swizzle(p[32*w +: 32]));
        chk("rd_not_early", cmd_valid, 0);
        put_word(host_swizzle(p[255:224]));
        exp_q.push_back(p);
        chk("rd_valid", cmd_valid, 1);
        chk("rd_is_read", cmd_is_read, 1);
        chk("rd_addr", cmd_addr, 31);
        drain();

        // Reserved bit 200 set: still forwarded, error sticks.
        send_pkt(mk_pkt(1'b1, 1'b0, 27'd5, 128'h55, 99'd1 << (200 - 157)));
        chk("rsvd_set", err_reserved, 1);
        drain();
        send_pkt(mk_pkt(1'b0, 1'b0, 27'd6, 128'h66, '0));
        drain();
        chk("rsvd_sticky", err_reserved, 1);
        chk("rsvd_count", pkt_count, 36);

        // Backpressure: two packets with cmd_ready low, then a dropped word.
        cmd_ready = 1'b0;
        pa = mk_pkt(1'b1, 1'b0, 27'd100, 128'hAAAA, '0);
        pb = mk_pkt(1'b1, 1'b1, 27'd200, 128'hBBBB, '0);
        send_pkt(pa);
        send_pkt(pb);
        chk("bp_ep_ready_low", ep_ready, 0);
        chk("bp_no_ovf_yet", err_overflow, 0);
        put_word(32'hDEAD_BEEF);
        chk("bp_overflow", err_overflow, 1);
        chk("bp_still_held", ep_ready, 0);
        idle(2);
        chk("bp_held_addr", cmd_addr, 100);
        cmd_ready = 1'b1;
        idle(1);
        chk("bp_second_valid", cmd_valid, 1);
        chk("bp_second_addr", cmd_addr, 200);
        chk("bp_ep_ready_back", ep_ready, 1);
        drain();
        chk("bp_count", pkt_count, 38);

        // Reset with a held command and a partial packet in flight.
        cmd_ready = 1'b0;
        send_pkt(mk_pkt(1'b1, 1'b0, 27'd7, 128'h77, '0));
        p = mk_pkt(1'b1, 1'b0, 27'd8, 128'h88, '0);
        for (int w = 0; w < 5; w++) put_word(host_swizzle(p[32*w +: 32]));
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        cmd_ready = 1'b1;
        p = mk_pkt(1'b1, 1'b1, 27'h7FF_FFFF, {4{32'hCAFE_F00D}}, '0);
        send_pkt(p);
        chk("rst_fresh_addr", cmd_addr, 27'h7FF_FFFF);
        chk("rst_fresh_wdata", cmd_wdata, {4{32'hCAFE_F00D}});
        chk("rst_errs_clear", {err_reserved, err_overflow}, 0);
        idle(1);
        chk("rst_fresh_count", pkt_count, 1);
        drain();
        idle(2);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
